bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the serial sequence detector.
//  - Accepts WIDTH-bit words over a valid/ready handshake.
//  - Presents one bit per clock on x, which drives the detector's serial input directly.
//  - A one-entry holding buffer lets consecutive words stream with no idle gap.
//  - While not shifting, x is held at IDLE_BIT so the detector sees a defined level.
// PARAMETERS
//  WIDTH      8   word width in bits, >=2
//  MSB_FIRST  1   1: shift out din[WIDTH-1] first; 0: din[0] first
//  IDLE_BIT   0   value driven on x whenever x_valid=0
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  din        in   WIDTH  parallel word
//  din_valid  in   1      din is offered
//  din_ready  out  1      block can take din this cycle; transfer = din_valid & din_ready
//  x          out  1      serial bit to the detector
//  x_valid    out  1      x carries a data bit this cycle
//  busy       out  1      SHIFT state or holding buffer occupied
//  word_done  out  1      one-cycle pulse, coincident with the last bit of a word on x
// BEHAVIOUR
//  Reset values
//  - When rst=1 at a clock edge: state=IDLE, shift reg=0, cnt=0, hold_full=0.
//  - Registered outputs after that edge: x=IDLE_BIT, x_valid=0, busy=0, word_done=0.
//  - din_ready is forced 0 while rst=1, so no transfer is taken in a reset cycle.
//  Registers
//  - shift reg sh[WIDTH-1:0]
//  - bit counter cnt[$clog2(WIDTH)-1:0]
//  - hold[WIDTH-1:0] and hold_full
//  - FSM, 2 states: IDLE, SHIFT
//  Output decode and ready
//  - x = MSB_FIRST ? sh[WIDTH-1] : sh[0] in SHIFT; IDLE_BIT in IDLE.
//  - x_valid = (state==SHIFT).
//  - word_done = SHIFT & cnt==WIDTH-1.
//  - din_ready = !rst & !hold_full.
//  IDLE
//  - On transfer: din loads straight into sh (hold bypassed), cnt=0, go to SHIFT.
//  - Latency: word transferred in cycle N, its first bit appears on x in cycle N+1.
//  SHIFT, cnt<WIDTH-1
//  - sh shifts toward the output end, zero-filling; cnt++.
//  - A transfer in this cycle writes hold and sets hold_full.
//  SHIFT, cnt==WIDTH-1 (last bit), evaluated in priority order
//  - (a) hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT.
//        din_ready was 0, so no transfer can coincide.
//  - (b) else, transfer this cycle: sh<=din directly, cnt<=0, stay in SHIFT.
//  - (c) else: go to IDLE.
//  - Cases (a) and (b) give zero idle cycles between words.
//  Boundary rules
//  - A full hold buffer never overwrites; din_ready stays 0 until the hold register drains.
//  - din is sampled only on a transfer and need not be stable afterwards.
//  - Reset mid-word: the in-flight word and the held word are discarded, with no partial word_done.
//    From the next cycle x=IDLE_BIT and x_valid=0.
//  - cnt never exceeds WIDTH-1. WIDTH that is not a power of two is supported through the explicit compare.
// STRUCTURE
//  - Shared package serial_defs: FSM state encodings (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH constant.
//  - One sub-module, word_hold_reg: one-entry buffer (load, take, data, full). Everything else stays inline.
// TESTING  (WIDTH=8, IDLE_BIT=0 unless stated)
//  1 Reset: rst high for 2 cycles, then low.
//    -> x=0, x_valid=0, busy=0, word_done=0; din_ready=0 during rst and 1 in the first cycle after.
//  2 Single word, MSB_FIRST=1: 8'hB5 transferred in cycle 0.
//    -> x in cycles 1..8 = 1,0,1,1,0,1,0,1; word_done only in cycle 8; x_valid=0 in cycle 9.
//  3 Back-to-back: 8'hA0 then 8'h0D, din_valid held high.
//    -> 16 contiguous x_valid cycles with no gap; din_ready=0 while hold_full; busy high throughout.
//  4 Late arrival: second word transferred exactly in the first word's last-bit cycle, hold empty.
//    -> second word's first bit appears in the next cycle; no IDLE cycle in between.
//  5 Reset mid-word: rst asserted while bit 3 is on x, with the hold buffer full.
//    -> next cycle x_valid=0, busy=0; the next transfer starts a fresh word at bit 0.
//  6 LSB-first with detector attached: MSB_FIRST=0, 8'h05.
//    -> x = 1,0,1,0,0,0,0,0; detector output z asserted one cycle after the third bit.

Source files
------------

// File: rtl/serial_defs.sv
// Shared definitions for the serial front end:
// FSM encodings and default word width.
package serial_defs;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/word_hold_reg.sv
// One-entry holding buffer: filled by load,
// emptied by take, never overwritten while full.
module word_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_take,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // capture a word on load, release it on take
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
    end else if (i_load && !r_full) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one bit per
// clock on x, words streamed back to back.
module bit_serializer
  import serial_defs::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_n;
  logic [WIDTH-1:0] w_sh_shift;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;
  logic             w_xfer;
  logic             w_last;
  logic             w_load;
  logic             w_take;
  logic [WIDTH-1:0] w_hold;
  logic             w_full;

  assign w_xfer = din_valid & din_ready;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // zero-filling shift toward the output end
  if (MSB_FIRST) begin : g_msb
    assign w_sh_shift = {r_sh[WIDTH-2:0], 1'b0};
  end else begin : g_lsb
    assign w_sh_shift = {1'b0, r_sh[WIDTH-1:1]};
  end

  word_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_take(w_take),
    .i_data(din),
    .o_data(w_hold),
    .o_full(w_full)
  );

  // state, shift register and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_sh    <= w_sh_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // next state: bypass load when idle, refill on last bit
  always_comb begin
    w_state_n = r_state;
    w_sh_n    = r_sh;
    w_cnt_n   = r_cnt;
    w_load    = 1'b0;
    w_take    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_sh_n    = din;
          w_cnt_n   = '0;
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_last) begin
          w_sh_n  = w_sh_shift;
          w_cnt_n = r_cnt + CW'(1);
          w_load  = w_xfer;
        end else if (w_full) begin
          w_sh_n  = w_hold;
          w_take  = 1'b1;
          w_cnt_n = '0;
        end else if (w_xfer) begin
          w_sh_n  = din;
          w_cnt_n = '0;
        end else begin
          w_sh_n    = w_sh_shift;
          w_cnt_n   = '0;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign din_ready = !rst && !w_full;
  assign x_valid   = (r_state == SHIFT);
  assign busy      = x_valid || w_full;
  assign word_done = x_valid && w_last;
  assign x         = !x_valid  ? IDLE_BIT :
                     MSB_FIRST ? r_sh[WIDTH-1] :
                                 r_sh[0];

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first
// serializers against a bit-queue model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din_v [2];
  logic         dv    [2];
  logic         rdy   [2];
  logic         xo    [2];
  logic         xv    [2];
  logic         bz    [2];
  logic         wd    [2];

  logic [1:0]   sb [2][$];
  int           xfer_cnt [2];
  int           n_chk  = 0;
  int           n_fail = 0;
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) u_msb (
    .clk(clk), .rst(rst),
    .din(din_v[0]), .din_valid(dv[0]),
    .din_ready(rdy[0]), .x(xo[0]),
    .x_valid(xv[0]), .busy(bz[0]),
    .word_done(wd[0])
  );

  bit_serializer #(
    .WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
  ) u_lsb (
    .clk(clk), .rst(rst),
    .din(din_v[1]), .din_valid(dv[1]),
    .din_ready(rdy[1]), .x(xo[1]),
    .x_valid(xv[1]), .busy(bz[1]),
    .word_done(wd[1])
  );

  task automatic chk(string nm, int k,
                     logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d t=%0t got %b want %b",
               nm, k, $time, act, exp);
    end
  endtask

  // model: a transferred word becomes W queued
  // bits in output order, last one flagged
  initial forever begin
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        sb[k].delete();
      end else if (dv[k] && rdy[k]) begin
        for (int i = 0; i < W; i++) begin
          int idx;
          idx = (k == 0) ? (W - 1 - i) : i;
          sb[k].push_back({din_v[k][idx], i == W - 1});
        end
        xfer_cnt[k]++;
      end
    end
  end

  // monitor: compare every cycle against queue
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        int         q;
        logic [1:0] e;
        logic       busy_e;
        q      = sb[k].size();
        busy_e = (q > 0);
        chk("x_valid", k, xv[k], busy_e);
        chk("busy", k, bz[k], busy_e);
        chk("din_ready", k, rdy[k],
            !rst && (q <= W));
        if (q > 0) begin
          e = sb[k].pop_front();
          chk("x", k, xo[k], e[1]);
          chk("word_done", k, wd[k], e[0]);
        end else begin
          chk("x_idle", k, xo[k], 1'b0);
          chk("word_done_idle", k, wd[k], 1'b0);
        end
      end
    end
  end

  // offer a word until taken; returns cycles waited
  task automatic send(input int k,
                      input logic [W-1:0] w,
                      output int t);
    int c0;
    c0 = xfer_cnt[k];
    t  = 0;
    din_v[k] = w;
    dv[k]    = 1'b1;
    while (xfer_cnt[k] == c0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    dv[k]    = 1'b0;
    din_v[k] = W'($urandom);
    n_chk++;
    if (xfer_cnt[k] == c0) begin
      n_fail++;
      $display("FAIL send_timeout lane%0d got no transfer want transfer", k);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    xfer_cnt[0] = 0;
    xfer_cnt[1] = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dv[k]    = 1'b0;
      din_v[k] = '0;
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(2);

    send(0, 8'hB5, t);
    send(1, 8'h05, t);
    cycles(12);

    send(0, 8'hA0, t);
    send(0, 8'h0D, t);
    cycles(20);

    send(0, 8'h3C, t);
    cycles(7);
    send(0, 8'hC3, t);
    n_chk++;
    if (t != 1) begin
      n_fail++;
      $display("FAIL late_xfer got %0d cycles want 1", t);
    end
    cycles(12);

    send(0, 8'hFF, t);
    send(0, 8'h81, t);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    send(0, 8'h96, t);
    cycles(12);

    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        dv[k]    = ($urandom_range(0, 3) != 0);
        din_v[k] = W'($urandom);
      end
      rst = ($urandom_range(0, 79) == 0);
      cycles(1);
    end
    rst   = 1'b0;
    dv[0] = 1'b0;
    dv[1] = 1'b0;
    cycles(30);

    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (sb[k].size() != 0) begin
        n_fail++;
        $display("FAIL drain lane%0d got %0d bits left want 0",
                 k, sb[k].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
